// File: rtl/kernel_launcher.sv
// Batch initiator for a start/ready/done kernel: issues num_jobs runs, watchdogs each one, pulses all_done.
// Optional busy-cycle counter on perf_cycles is built when LAUNCH_PERF_EN is defined.
module kernel_launcher #(
    parameter int JOB_CNT_W      = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TIMEOUT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [JOB_CNT_W-1:0] num_jobs,
    output logic                 busy,
    output logic                 all_done,
    output logic                 timeout_err,
    output logic [JOB_CNT_W-1:0] jobs_completed,
    output logic                 kernel_start,
    input  logic                 kernel_ready,
    input  logic                 kernel_done,
    output logic [15:0]          perf_cycles
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_RDY  = 3'd1;
    localparam logic [2:0] ISSUE     = 3'd2;
    localparam logic [2:0] WAIT_ACK  = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;
    localparam logic [2:0] FINISH    = 3'd5;
    localparam logic [2:0] ERROR     = 3'd6;

    logic [2:0]           state;
    logic [2:0]           next_state;
    logic [JOB_CNT_W-1:0] remaining;
    logic [TIMEOUT_W-1:0] wdog;
    logic                 accept_go;
    logic                 complete;
    logic                 wdog_expired;

    // Kernel handshake: a one-cycle kernel_start is accepted when the kernel drops
    // kernel_ready; the run is finished when kernel_ready and kernel_done are both high.
    assign accept_go    = go && ((state == IDLE) || (state == ERROR));
    assign complete     = (state == WAIT_DONE) && kernel_ready && kernel_done;
    assign wdog_expired = (wdog == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        next_state = state;
        case (state)
            IDLE, ERROR: begin
                if (go) begin
                    if (num_jobs == '0)    next_state = FINISH;
                    else if (kernel_ready) next_state = ISSUE;
                    else                   next_state = WAIT_RDY;
                end
            end
            WAIT_RDY:  if (kernel_ready) next_state = ISSUE;
            ISSUE:     next_state = WAIT_ACK;
            // Ready still high here is left over from the previous run, not a completion.
            WAIT_ACK: begin
                if (!kernel_ready)     next_state = WAIT_DONE;
                else if (wdog_expired) next_state = ERROR;
            end
            WAIT_DONE: begin
                if (complete)          next_state = (remaining == JOB_CNT_W'(1)) ? FINISH : ISSUE;
                else if (wdog_expired) next_state = ERROR;
            end
            FINISH:    next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            remaining      <= '0;
            jobs_completed <= '0;
            timeout_err    <= 1'b0;
            wdog           <= '0;
        end else begin
            state <= next_state;

            if (accept_go) begin
                remaining      <= num_jobs;
                jobs_completed <= '0;
                timeout_err    <= 1'b0;
            end else begin
                if (complete) begin
                    remaining      <= remaining - JOB_CNT_W'(1);
                    jobs_completed <= jobs_completed + JOB_CNT_W'(1);
                end
                if ((next_state == ERROR) && (state != ERROR)) timeout_err <= 1'b1;
            end

            // Watchdog restarts on every state change and counts dwell time in the wait states.
            if (next_state != state)
                wdog <= '0;
            else if ((state == WAIT_ACK) || (state == WAIT_DONE))
                wdog <= wdog + TIMEOUT_W'(1);
        end
    end

    assign busy         = (state != IDLE) && (state != ERROR);
    assign all_done     = (state == FINISH);
    assign kernel_start = (state == ISSUE);

`ifdef LAUNCH_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            perf_q <= '0;
        else if (accept_go)
            perf_q <= '0;
        else if (busy && (perf_q != 16'hFFFF))
            perf_q <= perf_q + 16'd1;
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_kernel_launcher.sv
// Bench for kernel_launcher: behavioural kernel with configurable accept delay and latency,
// batch-level reference model for starts, completions and busy time.
module tb_kernel_launcher;

    localparam int W = 8;
    localparam int T = 8;

    logic         clk;
    logic         rst;
    logic         go;
    logic [W-1:0] num_jobs;
    logic         busy;
    logic         all_done;
    logic         timeout_err;
    logic [W-1:0] jobs_completed;
    logic         kernel_start;
    logic         kernel_ready;
    logic         kernel_done;
    logic [15:0]  perf_cycles;

    int checks = 0;
    int errors = 0;

    // Observed event counts, advanced once per cycle.
    int start_cnt = 0;
    int done_cnt  = 0;
    int busy_cnt  = 0;
    logic [W-1:0] prev_jc = '0;
    logic [W-1:0] exp_q[$];

    // Kernel behaviour knobs: ready stays high cfg_d cycles after start, then cfg_l busy cycles.
    int cfg_d   = 0;
    int cfg_l   = 3;
    bit k_hang  = 1'b0;
    bit k_block = 1'b0;
    bit k_early = 1'b0;
    bit k_active = 1'b0;
    int k_e = 0;
    int k_d = 0;
    int k_l = 0;

    kernel_launcher #(
        .JOB_CNT_W     (W),
        .TIMEOUT_CYCLES(T),
        .TIMEOUT_W     (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .go            (go),
        .num_jobs      (num_jobs),
        .busy          (busy),
        .all_done      (all_done),
        .timeout_err   (timeout_err),
        .jobs_completed(jobs_completed),
        .kernel_start  (kernel_start),
        .kernel_ready  (kernel_ready),
        .kernel_done   (kernel_done),
        .perf_cycles   (perf_cycles)
    );

    // Clock and global time limit.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    // Monitor + scoreboard (negedge+1), then kernel model (negedge+2).
    initial begin
        logic [W-1:0] e;
        kernel_ready = 1'b1;
        kernel_done  = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (kernel_start) begin
                start_cnt++;
                checks++;
                if (k_active) begin
                    errors++;
                    $display("FAIL start_overlap: kernel_start=1 while kernel run still active");
                end
            end
            if (all_done) done_cnt++;
            if (busy) busy_cnt++;
            if ((jobs_completed !== prev_jc) && (jobs_completed != '0)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL jc_unexpected: jobs_completed=%0d with no expected value", jobs_completed);
                end else begin
                    e = exp_q.pop_front();
                    if (jobs_completed !== e) begin
                        errors++;
                        $display("FAIL jc_step: got %0d want %0d", jobs_completed, e);
                    end
                end
            end
            prev_jc = jobs_completed;
            #1;
            if (!rst) begin
                k_active     = 1'b0;
                kernel_ready = !k_block;
                kernel_done  = 1'b0;
            end else begin
                if (kernel_start) begin
                    k_active = 1'b1;
                    k_e = 0;
                    k_d = cfg_d;
                    k_l = cfg_l;
                end else if (k_active) begin
                    k_e++;
                end
                if (k_active) begin
                    if (k_e == k_d) begin
                        kernel_ready = 1'b0;
                        kernel_done  = k_early;
                    end
                    if (!k_hang && (k_e >= k_d + k_l)) begin
                        kernel_ready = 1'b1;
                        kernel_done  = 1'b1;
                        k_active     = 1'b0;
                    end
                end else begin
                    kernel_ready = !k_block;
                end
            end
        end
    end

    // Driver: one-cycle go, then scramble num_jobs to show it is not re-sampled.
    task automatic issue_go(input int n);
        @(negedge clk);
        go = 1'b1;
        num_jobs = n[W-1:0];
        @(negedge clk);
        go = 1'b0;
        num_jobs = W'($urandom_range(0, 255));
    endtask

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #3;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Reference: each run lasts accept delay + latency + 1 cycles, plus one FINISH cycle.
    task automatic run_batch(input int n, input int d, input int l, input bit early, input bit stray);
        int b_start;
        int b_done;
        int b_busy;
        int exp_busy;
        logic [15:0] exp_perf;
        bit ok;
        cfg_d = d;
        cfg_l = l;
        k_early = early;
        b_start = start_cnt;
        b_done  = done_cnt;
        b_busy  = busy_cnt;
        for (int i = 1; i <= n; i++) exp_q.push_back(W'(i));
        exp_busy = (n == 0) ? 1 : n * (d + l + 1) + 1;
`ifdef LAUNCH_PERF_EN
        exp_perf = 16'(exp_busy);
`else
        exp_perf = 16'h0000;
`endif
        issue_go(n);
        if (stray) begin
            @(negedge clk);
            go = 1'b1;
            num_jobs = W'($urandom_range(1, 255));
            @(negedge clk);
            go = 1'b0;
        end
        wait_end(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL batch_end_wait: busy stuck, n=%0d", n); end
        checks++;
        if (start_cnt - b_start != n) begin
            errors++; $display("FAIL batch_starts: got %0d want %0d", start_cnt - b_start, n);
        end
        checks++;
        if (done_cnt - b_done != 1) begin
            errors++; $display("FAIL batch_all_done: got %0d pulses want 1", done_cnt - b_done);
        end
        checks++;
        if (busy_cnt - b_busy != exp_busy) begin
            errors++; $display("FAIL batch_busy_cycles: got %0d want %0d (n=%0d d=%0d l=%0d)",
                               busy_cnt - b_busy, exp_busy, n, d, l);
        end
        checks++;
        if (jobs_completed !== W'(n)) begin
            errors++; $display("FAIL batch_jobs_completed: got %0d want %0d", jobs_completed, n);
        end
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL batch_timeout_err: got %b want 0", timeout_err);
        end
        checks++;
        if (perf_cycles !== exp_perf) begin
            errors++; $display("FAIL batch_perf: got %0d want %0d", perf_cycles, exp_perf);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL batch_scoreboard: %0d completions missing", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        go = 1'b0;
        num_jobs = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (all_done !== 1'b0) begin errors++; $display("FAIL reset_all_done: got %b want 0", all_done); end
        checks++;
        if (kernel_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", kernel_start); end
        checks++;
        if (jobs_completed !== '0) begin errors++; $display("FAIL reset_jc: got %0d want 0", jobs_completed); end
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        checks++;
        if (perf_cycles !== 16'h0000) begin errors++; $display("FAIL reset_perf: got %0d want 0", perf_cycles); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        run_batch(1, 0, 3, 1'b0, 1'b0);
    endtask

    task automatic test_batch();
        run_batch(4, 0, 3, 1'b0, 1'b1);
        for (int r = 0; r < 6; r++)
            run_batch($urandom_range(1, 6), $urandom_range(0, 2), $urandom_range(2, 6),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_zero_stale();
        int b_start;
        int b_done;
        bit ok;
        b_start = start_cnt;
        b_done  = done_cnt;
        issue_go(0);
        checks++;
        if (all_done !== 1'b1) begin errors++; $display("FAIL zero_all_done_timing: got %b want 1", all_done); end
        wait_end(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL zero_end_wait: busy stuck"); end
        checks++;
        if (start_cnt != b_start) begin errors++; $display("FAIL zero_starts: got %0d want 0", start_cnt - b_start); end
        checks++;
        if (done_cnt - b_done != 1) begin errors++; $display("FAIL zero_all_done: got %0d want 1", done_cnt - b_done); end
        checks++;
        if (jobs_completed !== '0) begin errors++; $display("FAIL zero_jc: got %0d want 0", jobs_completed); end
        // Kernel still shows ready=1/done=1 and keeps them for 3 cycles after the new start.
        run_batch(1, 3, 3, 1'b0, 1'b0);
    endtask

    task automatic test_not_ready();
        int b_busy;
        int b_done;
        bit ok;
        cfg_d = 0;
        cfg_l = 3;
        k_early = 1'b0;
        k_block = 1'b1;
        @(negedge clk);
        b_busy = busy_cnt;
        b_done = done_cnt;
        exp_q.push_back(W'(1));
        issue_go(1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            #3;
            checks++;
            if (!(busy === 1'b1 && kernel_start === 1'b0 && timeout_err === 1'b0)) begin
                errors++;
                $display("FAIL not_ready_hold: cycle %0d busy=%b start=%b terr=%b want 1 0 0",
                         i, busy, kernel_start, timeout_err);
            end
        end
        k_block = 1'b0;
        @(negedge clk);
        #3;
        checks++;
        if (kernel_start !== 1'b0) begin errors++; $display("FAIL not_ready_early_start: got %b want 0", kernel_start); end
        @(negedge clk);
        #3;
        checks++;
        if (kernel_start !== 1'b1) begin errors++; $display("FAIL not_ready_start: got %b want 1", kernel_start); end
        wait_end(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL not_ready_end_wait: busy stuck"); end
        checks++;
        if (busy_cnt - b_busy != 16) begin
            errors++; $display("FAIL not_ready_busy_cycles: got %0d want 16", busy_cnt - b_busy);
        end
        checks++;
        if (done_cnt - b_done != 1) begin errors++; $display("FAIL not_ready_all_done: got %0d want 1", done_cnt - b_done); end
        checks++;
        if (jobs_completed !== W'(1)) begin errors++; $display("FAIL not_ready_jc: got %0d want 1", jobs_completed); end
    endtask

    task automatic test_timeout();
        int b_start;
        int b_done;
        int b_busy;
        logic [15:0] exp_perf;
        bit ok;
        bit seen;
        cfg_d = 0;
        cfg_l = 3;
        k_early = 1'b0;
        k_hang = 1'b0;
`ifdef LAUNCH_PERF_EN
        exp_perf = 16'(4 + T + 2);
`else
        exp_perf = 16'h0000;
`endif
        b_start = start_cnt;
        b_done  = done_cnt;
        b_busy  = busy_cnt;
        exp_q.push_back(W'(1));
        issue_go(2);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (jobs_completed == W'(1)) begin
                k_hang = 1'b1;
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL timeout_first_run: jobs_completed=%0d want 1", jobs_completed); end
        wait_end(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_end_wait: busy stuck"); end
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", timeout_err); end
        checks++;
        if (busy_cnt - b_busy != 4 + T + 2) begin
            errors++; $display("FAIL timeout_busy_cycles: got %0d want %0d", busy_cnt - b_busy, 4 + T + 2);
        end
        checks++;
        if (done_cnt != b_done) begin errors++; $display("FAIL timeout_all_done: got %0d want 0", done_cnt - b_done); end
        checks++;
        if (start_cnt - b_start != 2) begin errors++; $display("FAIL timeout_starts: got %0d want 2", start_cnt - b_start); end
        checks++;
        if (jobs_completed !== W'(1)) begin errors++; $display("FAIL timeout_jc_hold: got %0d want 1", jobs_completed); end
        checks++;
        if (perf_cycles !== exp_perf) begin errors++; $display("FAIL timeout_perf: got %0d want %0d", perf_cycles, exp_perf); end
        repeat (3) @(negedge clk);
        checks++;
        if (!(timeout_err === 1'b1 && busy === 1'b0)) begin
            errors++; $display("FAIL timeout_sticky: terr=%b busy=%b want 1 0", timeout_err, busy);
        end
        k_hang = 1'b0;
        repeat (2) @(negedge clk);
        run_batch(1, 0, 3, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int b_done;
        cfg_d = 0;
        cfg_l = 5;
        k_early = 1'b0;
        b_done = done_cnt;
        issue_go(2);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_mid_pre_busy: got %b want 1", busy); end
        rst = 1'b0;
        #1;
        checks++;
        if (!(busy === 1'b0 && all_done === 1'b0 && kernel_start === 1'b0 &&
              jobs_completed === '0 && timeout_err === 1'b0 && perf_cycles === 16'h0000)) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b start=%b jc=%0d terr=%b perf=%0d want all 0",
                     busy, all_done, kernel_start, jobs_completed, timeout_err, perf_cycles);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        checks++;
        if (done_cnt != b_done) begin errors++; $display("FAIL reset_mid_all_done: got %0d pulses want 0", done_cnt - b_done); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_idle: busy=%b want 0", busy); end
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        go = 1'b0;
        num_jobs = '0;
        #1 rst = 1'b0;
        test_reset();
        test_single();
        test_batch();
        test_zero_stale();
        test_not_ready();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kernel_launcher.md
Name: kernel_launcher

Overview:
- Initiator side of the start/ready/done kernel handshake. Issues a batch of N back-to-back kernel runs to one start/ready/done kernel (e.g. read_write_ram) and counts completions.
- Watchdogs each run for a timeout.
- Reports batch completion to the host sequencer with a one-cycle all_done pulse.

Parameters:
JOB_CNT_W, 8, width of num_jobs and jobs_completed
TIMEOUT_CYCLES, 64, max cycles allowed in WAIT_ACK or WAIT_DONE before error (must fit in TIMEOUT_W)
TIMEOUT_W, 8, width of watchdog counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
go  in  1  start batch; sampled in IDLE/ERROR only
num_jobs  in  JOB_CNT_W  runs in batch; latched on accepted go
busy  out  1  batch in progress
all_done  out  1  one-cycle pulse at batch end (success only)
timeout_err  out  1  sticky watchdog error
jobs_completed  out  JOB_CNT_W  runs completed in current/last batch
kernel_start  out  1  start to kernel, exactly one cycle per run
kernel_ready  in  1  kernel idle/accepting
kernel_done  in  1  kernel done level (valid when kernel_ready=1)
perf_cycles  out  16  busy-cycle counter (see Optional Feature)

Behaviour:
- Reset (rst=0, async): state=IDLE; busy, all_done, timeout_err, kernel_start=0; jobs_completed=0; internal counters=0. Reset mid-batch aborts immediately, with no all_done.
- All outputs are registered or Moore decodes of registered state. No combinational path from kernel_* to kernel_start.
- States: IDLE, WAIT_RDY, ISSUE, WAIT_ACK, WAIT_DONE, FINISH, ERROR.
- IDLE, go=1:
  - Latch num_jobs into remaining.
  - Clear jobs_completed and timeout_err.
  - If num_jobs=0, go to FINISH.
  - Else if kernel_ready=1, go to ISSUE; else go to WAIT_RDY.
- WAIT_RDY: go to ISSUE when kernel_ready=1. No timeout here.
- ISSUE: kernel_start=1 for this single cycle; next state WAIT_ACK.
- WAIT_ACK:
  - Wait for kernel_ready=0 (kernel accepted). Stale done=1/ready=1 from a prior run is ignored here.
  - On kernel_ready=0, go to WAIT_DONE.
- WAIT_DONE:
  - On kernel_ready=1 && kernel_done=1: jobs_completed+1, remaining-1.
  - If remaining was 1, go to FINISH; else go to ISSUE (next run starts the following cycle).
- FINISH: all_done=1 for one cycle, then IDLE.
- Watchdog:
  - Counter clears on entry to WAIT_ACK and WAIT_DONE and increments each cycle in them.
  - Reaching TIMEOUT_CYCLES goes to ERROR, with timeout_err=1.
  - jobs_completed holds the count at time of error.
- ERROR: busy=0; timeout_err stays 1. go=1 behaves as in IDLE and restarts a fresh batch.
- busy=1 in WAIT_RDY, ISSUE, WAIT_ACK, WAIT_DONE, FINISH; 0 in IDLE, ERROR.
- go while busy=1 is ignored. num_jobs changes after latch have no effect.
- kernel_done=1 with kernel_ready=0 is not a completion.
- Minimum per-run overhead: ISSUE + WAIT_ACK (1 cycle) + kernel latency + completion cycle.
- jobs_completed cannot overflow (bounded by num_jobs).

Optional Feature:
- Macro LAUNCH_PERF_EN.
- Defined:
  - perf_cycles clears on accepted go.
  - Increments every cycle busy=1, saturating at 16'hFFFF.
  - Holds after batch end or error; reset to 0.
- Undefined: perf_cycles tied to 16'h0000; no counter logic. Port list is unchanged.

Test Plan:
- Reset: hold rst=0 across edges, with kernel model ready=1, done=0 -> busy=0, all_done=0, kernel_start=0, jobs_completed=0, timeout_err=0. Assert rst=0 mid-WAIT_DONE -> same values immediately, no all_done pulse.
- Single run: 3-cycle kernel model (ready drops the cycle after start; ready=1, done=1 three cycles later), num_jobs=1, go pulse -> exactly one kernel_start pulse, all_done pulses once, jobs_completed=1, busy falls with FINISH exit.
- Batch: num_jobs=4 -> four kernel_start pulses, each issued only after prior ready=1/done=1, jobs_completed=4, one all_done. With LAUNCH_PERF_EN, perf_cycles equals the counted busy cycles.
- Zero jobs and stale done: num_jobs=0 -> no kernel_start, all_done the cycle after go. Then num_jobs=1 while kernel still shows done=1 from prior run -> no false completion in WAIT_ACK.
- Not ready: kernel_ready=0 for 10 cycles after go -> launcher stays in WAIT_RDY, busy=1, no start and no timeout; start issues the cycle after ready rises.
- Timeout: TIMEOUT_CYCLES=8, kernel never returns ready after start -> timeout_err=1 after 8 cycles in WAIT_DONE, busy=0, no all_done. New go clears timeout_err and a good run completes.
